// File: rtl/timer_ctrl_fsm.sv
// rtl/timer_ctrl_fsm.sv - stopwatch button controller: sync, debounce, press FSM, timer control pulses
module timer_ctrl_fsm #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_PULSE     = 4
) (
  input  logic       sys_clk,
  input  logic       rst_b,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  output logic       timer_pause,
  output logic       timer_clear,
  output logic       timer_reset,
  output logic [1:0] ctrl_state,
  output logic       press_ignored
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(RESET_PULSE + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUNNING   = 2'd1;
  localparam logic [1:0] ST_PAUSED    = 2'd2;
  localparam logic [1:0] ST_RESETTING = 2'd3;

  localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_PULSE);
  localparam logic [RCW-1:0] RST_ONE  = RCW'(1);

  // Bit 0 carries start/stop, bit 1 carries reset through the whole input path.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, level_q, level_dly_q, press_q;
  logic [DCW-1:0] dcnt_q [2];

  assign btn_raw = {btn_reset, btn_start_stop};

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DB_LAST) begin
          level_q[i] <= sync2_q[i];
          dcnt_q[i]  <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic           ss_ev, rs_ev;
  logic [1:0]     state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           ign_d;

  assign ss_ev = press_q[0];
  assign rs_ev = press_q[1];

  // Simultaneous presses: start/stop wins only in RUNNING, reset wins elsewhere.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    ign_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSED: begin
        if (rs_ev) begin
          state_d = ST_RESETTING;
          rcnt_d  = RST_LOAD;
          ign_d   = ss_ev;
        end else if (ss_ev) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (ss_ev) state_d = ST_PAUSED;
        ign_d = rs_ev;
      end
      default: begin
        ign_d  = ss_ev | rs_ev;
        rcnt_d = rcnt_q - 1'b1;
        if (rcnt_q == RST_ONE) state_d = ST_IDLE;
      end
    endcase
  end

  logic timer_pause_q, timer_clear_q, timer_reset_q, press_ignored_q;

  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q         <= ST_IDLE;
      rcnt_q          <= '0;
      timer_pause_q   <= 1'b1;
      timer_clear_q   <= 1'b0;
      timer_reset_q   <= 1'b0;
      press_ignored_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rcnt_q          <= rcnt_d;
      timer_pause_q   <= (state_d != ST_RUNNING);
      timer_clear_q   <= (state_q == ST_RESETTING) && (state_d == ST_IDLE);
      timer_reset_q   <= (state_d == ST_RESETTING);
      press_ignored_q <= ign_d;
    end
  end

  assign ctrl_state    = state_q;
  assign timer_pause   = timer_pause_q;
  assign timer_clear   = timer_clear_q;
  assign timer_reset   = timer_reset_q;
  assign press_ignored = press_ignored_q;

endmodule
